// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor. One full-adder cell and a carry
// register handle one bit per cycle, LSB first, with a valid/ready handshake
// on both sides. Subtract mode adds the inverted B operand plus an inverted
// carry-in. carry_out and signed overflow are registered on the MSB step.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             bit_sum;
  logic             carry_next;
  logic [WIDTH-1:0] sum_next;

  // Full-adder cell on the current LSBs; the result bit enters at the top
  // of sum so that after WIDTH steps the word is in place.
  always_comb begin
    bit_sum    = a_sh[0] ^ b_sh[0] ^ carry;
    carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    sum_next   = sum >> 1;
    sum_next[WIDTH-1] = bit_sum;
  end

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      carry     <= 1'b0;
      cnt       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh     <= a;
            b_sh     <= sub ? ~b : b;
            carry    <= carry_in ^ sub;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= SHIFT;
          end else begin
            in_ready <= 1'b1;
          end
        end
        SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          sum   <= sum_next;
          carry <= carry_next;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            carry_out <= carry_next;
            overflow  <= carry ^ carry_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
